// File: rtl/fma_result_writeback_if.sv
// Handshake and data bundle between the FMA rounder, the writeback
// buffer and the register-file writeback port, plus the fflags CSR hooks.
interface fma_result_writeback_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 5,
  parameter int PARM_CNT  = 32
);
  // rounder side
  logic                          In_valid_i;
  logic                          In_ready_o;
  logic                          Sign_i;
  logic [PARM_EXP-1:0]           Exp_i;
  logic [PARM_MANT-1:0]          Mant_i;
  logic [PARM_TAG-1:0]           Tag_i;
  logic                          Invalid_i;
  logic                          Overflow_i;
  logic                          Underflow_i;
  logic                          Inexact_i;
  // writeback side
  logic                          Out_valid_o;
  logic                          Out_ready_i;
  logic [PARM_EXP+PARM_MANT:0]   Result_o;
  logic [PARM_TAG-1:0]           Tag_o;
  logic [4:0]                    Flags_o;
  // CSR side
  logic                          Fflags_wr_i;
  logic [4:0]                    Fflags_wdata_i;
  logic [4:0]                    Fflags_o;
  logic [PARM_CNT-1:0]           Op_count_o;

  // buffer view
  modport slave (
    input  In_valid_i, Sign_i, Exp_i, Mant_i, Tag_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i,
           Out_ready_i, Fflags_wr_i, Fflags_wdata_i,
    output In_ready_o, Out_valid_o, Result_o, Tag_o, Flags_o,
           Fflags_o, Op_count_o
  );

  // driver view (rounder + writeback + CSR combined)
  modport master (
    output In_valid_i, Sign_i, Exp_i, Mant_i, Tag_i,
           Invalid_i, Overflow_i, Underflow_i, Inexact_i,
           Out_ready_i, Fflags_wr_i, Fflags_wdata_i,
    input  In_ready_o, Out_valid_o, Result_o, Tag_o, Flags_o,
           Fflags_o, Op_count_o
  );
endinterface

// File: rtl/fma_result_writeback.sv
// FMA result writeback buffer: packs rounded fields into an IEEE single
// word (canonical NaN), queues them in a small circular FIFO, hands them
// to writeback over valid/ready, and keeps sticky fflags and a retired-op
// counter that both update on retirement (pop).
module fma_result_writeback #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_DEPTH = 2,
  parameter int PARM_TAG   = 5,
  parameter int PARM_CNT   = 32
) (
  input  logic                  Clk_i,
  input  logic                  Rst_n_i,
  fma_result_writeback_if.slave wb
);

  localparam int W  = PARM_EXP + PARM_MANT + 1;
  localparam int PW = (PARM_DEPTH > 1) ? $clog2(PARM_DEPTH) : 1;
  localparam int CW = $clog2(PARM_DEPTH + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(PARM_DEPTH);

  // quiet NaN with positive sign and only the quiet bit set
  localparam logic [W-1:0] CANON_NAN =
    {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

  typedef struct packed {
    logic [W-1:0]        word;
    logic [PARM_TAG-1:0] tag;
    logic [4:0]          flags;   // {NV,DZ,OF,UF,NX}
  } entry_t;

  entry_t              mem_q   [PARM_DEPTH];
  entry_t              mem_d   [PARM_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic [4:0]          fflags_q, fflags_d;
  logic [PARM_CNT-1:0] op_cnt_q, op_cnt_d;

  logic   in_ready, out_valid, push, pop, is_nan;
  entry_t new_entry, head;

  // Handshake state comes from registered occupancy only, so In_ready
  // never depends combinationally on Out_ready.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = wb.In_valid_i & in_ready;
  assign pop       = out_valid & wb.Out_ready_i;
  assign head      = mem_q[rd_ptr_q];

  // Pack incoming fields; any NaN payload collapses to the canonical NaN.
  always_comb begin
    is_nan          = (&wb.Exp_i) & (|wb.Mant_i);
    new_entry.word  = is_nan ? CANON_NAN : {wb.Sign_i, wb.Exp_i, wb.Mant_i};
    new_entry.tag   = wb.Tag_i;
    new_entry.flags = {wb.Invalid_i, 1'b0, wb.Overflow_i, wb.Underflow_i,
                       wb.Inexact_i};
  end

  // FIFO pointer / occupancy / storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Retirement side effects; a CSR write lands before the retiring op ORs in.
  always_comb begin
    fflags_d = wb.Fflags_wr_i ? wb.Fflags_wdata_i : fflags_q;
    op_cnt_d = op_cnt_q;
    if (pop) begin
      fflags_d = fflags_d | head.flags;
      op_cnt_d = op_cnt_q + PARM_CNT'(1);
    end
  end

  // State registers; async reset drops every buffered entry immediately.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      for (int i = 0; i < PARM_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      op_cnt_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign wb.In_ready_o  = in_ready;
  assign wb.Out_valid_o = out_valid;
  assign wb.Result_o    = head.word;
  assign wb.Tag_o       = head.tag;
  assign wb.Flags_o     = head.flags;
  assign wb.Fflags_o    = fflags_q;
  assign wb.Op_count_o  = op_cnt_q;

endmodule

// File: tb/tb_fma_result_writeback.sv
// Bench for fma_result_writeback: directed scenarios plus random traffic,
// all checked against a queue-based model of the buffer.
module tb_fma_result_writeback;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_result_writeback_if #(.PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(5),
                            .PARM_CNT(32)) bus ();

  fma_result_writeback #(.PARM_EXP(8), .PARM_MANT(23), .PARM_DEPTH(DEPTH),
                         .PARM_TAG(5), .PARM_CNT(32)) dut (
    .Clk_i  (clk),
    .Rst_n_i(rst_n),
    .wb     (bus)
  );

  typedef struct {
    logic [31:0] w;
    logic [4:0]  t;
    logic [4:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  mff;
  logic [31:0] mcnt;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e,
                                       input logic [22:0] m);
    if (e == 8'd255 && m != 23'd0) return 32'h7FC0_0000;
    return (32'(s) << 31) + (32'(e) << 23) + 32'(m);
  endfunction

  task automatic chk_outputs();
    chk("in_ready", 32'(bus.In_ready_o), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(bus.Out_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("result", bus.Result_o, mq[0].w);
      chk("tag", 32'(bus.Tag_o), 32'(mq[0].t));
      chk("flags", 32'(bus.Flags_o), 32'(mq[0].f));
    end
    chk("fflags", 32'(bus.Fflags_o), 32'(mff));
    chk("op_count", bus.Op_count_o, mcnt);
  endtask

  // Called just after a falling edge: drive, model one rising edge, then
  // wait for the next falling edge and compare. fl = {NV,OF,UF,NX}.
  task automatic step(input logic iv, input logic s, input logic [7:0] e,
                      input logic [22:0] m, input logic [4:0] t,
                      input logic [3:0] fl, input logic ordy,
                      input logic fwr, input logic [4:0] fwd);
    logic push, pop;
    bus.In_valid_i     = iv;
    bus.Sign_i         = s;
    bus.Exp_i          = e;
    bus.Mant_i         = m;
    bus.Tag_i          = t;
    bus.Invalid_i      = fl[3];
    bus.Overflow_i     = fl[2];
    bus.Underflow_i    = fl[1];
    bus.Inexact_i      = fl[0];
    bus.Out_ready_i    = ordy;
    bus.Fflags_wr_i    = fwr;
    bus.Fflags_wdata_i = fwd;
    #1;
    chk("in_ready_no_comb", 32'(bus.In_ready_o), 32'(mq.size() < DEPTH));
    push = iv && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() > 0);
    mff  = fwr ? fwd : mff;
    if (pop) begin
      mff  = mff | mq[0].f;
      mcnt = mcnt + 1;
      void'(mq.pop_front());
    end
    if (push) mq.push_back('{pack(s, e, m), t, {fl[3], 1'b0, fl[2:0]}});
    @(negedge clk);
    chk_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 8'h0, 23'h0, 5'h0, 4'h0, ordy, 1'b0, 5'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  task automatic model_reset();
    mq.delete();
    mff  = 5'h0;
    mcnt = 32'h0;
  endtask

  initial begin
    logic [31:0] held, base;
    logic [7:0]  e;
    logic [22:0] m;
    model_reset();
    bus.In_valid_i = 0; bus.Sign_i = 0; bus.Exp_i = 0; bus.Mant_i = 0;
    bus.Tag_i = 0; bus.Invalid_i = 0; bus.Overflow_i = 0;
    bus.Underflow_i = 0; bus.Inexact_i = 0; bus.Out_ready_i = 0;
    bus.Fflags_wr_i = 0; bus.Fflags_wdata_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", bus.Result_o, 32'h0);
    chk("rst_tag", 32'(bus.Tag_o), 32'h0);
    chk("rst_flags", 32'(bus.Flags_o), 32'h0);
    chk_outputs();

    // single op: 2.0f
    step(1'b1, 1'b0, 8'h80, 23'h0, 5'd3, 4'h0, 1'b1, 1'b0, 5'h0);
    chk("single_result", bus.Result_o, 32'h4000_0000);
    idle(1'b1);
    chk("single_opcnt", bus.Op_count_o, 32'd1);
    chk("single_fflags", 32'(bus.Fflags_o), 32'h0);

    // NaN canonicalisation
    step(1'b1, 1'b1, 8'hFF, 23'h1, 5'd7, 4'b1000, 1'b0, 1'b0, 5'h0);
    chk("nan_result", bus.Result_o, 32'h7FC0_0000);
    chk("nan_flags", 32'(bus.Flags_o), 32'h10);
    idle(1'b1);
    chk("nan_fflags", 32'(bus.Fflags_o), 32'h10);

    // infinity and negative zero keep their sign
    step(1'b1, 1'b1, 8'hFF, 23'h0, 5'd1, 4'b0100, 1'b0, 1'b0, 5'h0);
    chk("neg_inf", bus.Result_o, 32'hFF80_0000);
    drain();
    step(1'b1, 1'b1, 8'h00, 23'h0, 5'd2, 4'h0, 1'b0, 1'b0, 5'h0);
    chk("neg_zero", bus.Result_o, 32'h8000_0000);
    drain();

    // backpressure: A, B fill the buffer, C waits upstream
    step(1'b1, 1'b0, 8'h81, 23'h0A, 5'd10, 4'h1, 1'b0, 1'b0, 5'h0);
    held = bus.Result_o;
    step(1'b1, 1'b0, 8'h82, 23'h0B, 5'd11, 4'h0, 1'b0, 1'b0, 5'h0);
    chk("full_ready", 32'(bus.In_ready_o), 32'h0);
    step(1'b1, 1'b0, 8'h83, 23'h0C, 5'd12, 4'h0, 1'b0, 1'b0, 5'h0);
    chk("stall_stable", bus.Result_o, held);
    step(1'b1, 1'b0, 8'h83, 23'h0C, 5'd12, 4'h0, 1'b0, 1'b0, 5'h0);
    chk("stall_stable2", bus.Result_o, held);
    step(1'b1, 1'b0, 8'h83, 23'h0C, 5'd12, 4'h0, 1'b1, 1'b0, 5'h0);
    chk("order_b", 32'(bus.Tag_o), 32'd11);
    step(1'b1, 1'b0, 8'h83, 23'h0C, 5'd12, 4'h0, 1'b1, 1'b0, 5'h0);
    chk("order_c", 32'(bus.Tag_o), 32'd12);
    drain();

    // push and pop together at occupancy 1
    step(1'b1, 1'b0, 8'h10, 23'h0, 5'd0, 4'h0, 1'b0, 1'b0, 5'h0);
    base = bus.Op_count_o;
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b0, 8'h10, 23'(i), 5'(i), 4'h0, 1'b1, 1'b0, 5'h0);
    chk("sim_opcnt", bus.Op_count_o, base + 32'd10);
    chk("sim_valid", 32'(bus.Out_valid_o), 32'h1);
    chk("sim_ready", 32'(bus.In_ready_o), 32'h1);
    chk("sim_tag", 32'(bus.Tag_o), 32'd10);
    drain();

    // CSR write is ordered before the retiring op
    step(1'b0, 1'b0, 8'h0, 23'h0, 5'h0, 4'h0, 1'b0, 1'b1, 5'b00001);
    chk("csr_write", 32'(bus.Fflags_o), 32'h01);
    step(1'b1, 1'b0, 8'hFE, 23'h7FFFFF, 5'd4, 4'b0101, 1'b0, 1'b0, 5'h0);
    step(1'b0, 1'b0, 8'h0, 23'h0, 5'h0, 4'h0, 1'b1, 1'b1, 5'b00000);
    chk("csr_order", 32'(bus.Fflags_o), 32'h05);

    // async reset mid-stall with two entries held
    step(1'b1, 1'b0, 8'h90, 23'h5, 5'd20, 4'h1, 1'b0, 1'b0, 5'h0);
    step(1'b1, 1'b0, 8'h91, 23'h6, 5'd21, 4'h1, 1'b0, 1'b0, 5'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.Out_valid_o), 32'h0);
    chk("arst_ready", 32'(bus.In_ready_o), 32'h1);
    chk("arst_result", bus.Result_o, 32'h0);
    chk("arst_fflags", 32'(bus.Fflags_o), 32'h0);
    chk("arst_opcnt", bus.Op_count_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h7F, 23'h1234, 5'd9, 4'h0, 1'b0, 1'b0, 5'h0);
    chk("arst_first", bus.Result_o, 32'h3F80_1234);
    idle(1'b1);
    chk("arst_cnt1", bus.Op_count_o, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       e = 8'hFF;
        1:       e = 8'h00;
        default: e = 8'($urandom);
      endcase
      m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), e, m, 5'($urandom),
           4'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0), 5'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fma_result_writeback.md
Name: fma_result_writeback

Overview:
- Sits directly downstream of the FMA rounding stage.
- Captures each rounded result (sign/exponent/mantissa plus the IEEE exception flags) into a small elastic buffer.
- Packs the captured fields into a 32-bit IEEE-754 single word and canonicalises NaNs.
- Hands results to the register-file writeback port over a valid/ready handshake, and keeps the sticky RISC-V fflags accumulator and a retired-operation counter.

Parameters:
PARM_EXP, 8, exponent width
PARM_MANT, 23, stored mantissa width
PARM_DEPTH, 2, buffer entries (power of two, >=2)
PARM_TAG, 5, destination-register tag width
PARM_CNT, 32, retired-op counter width

Ports:
Clk_i  in  1  clock, rising edge
Rst_n_i  in  1  asynchronous active-low reset
In_valid_i  in  1  rounder result valid
In_ready_o  out  1  buffer can accept
Sign_i  in  1  rounded sign
Exp_i  in  PARM_EXP  rounded exponent
Mant_i  in  PARM_MANT  rounded mantissa
Tag_i  in  PARM_TAG  destination register
Invalid_i  in  1  NV flag
Overflow_i  in  1  OF flag
Underflow_i  in  1  UF flag
Inexact_i  in  1  NX flag
Out_valid_o  out  1  result available
Out_ready_i  in  1  writeback accepts
Result_o  out  PARM_EXP+PARM_MANT+1  packed IEEE word
Tag_o  out  PARM_TAG  destination of head entry
Flags_o  out  5  {NV,DZ,OF,UF,NX} of head entry
Fflags_wr_i  in  1  CSR write strobe
Fflags_wdata_i  in  5  CSR write value
Fflags_o  out  5  accumulated fflags
Op_count_o  out  PARM_CNT  retired-op count

Behaviour:
- Clock and reset: one clock Clk_i; reset Rst_n_i is asynchronous and active-low.
- Reset values: buffer empty; In_ready_o=1; Out_valid_o=0; Result_o, Tag_o, Flags_o, Fflags_o and Op_count_o all 0.
- Reset mid-operation discards all buffered entries.
- Buffer: circular FIFO with write pointer, read pointer and occupancy count (0..PARM_DEPTH).
- Push = In_valid_i & In_ready_o. Pop = Out_valid_o & Out_ready_i.
- In_ready_o = (count != PARM_DEPTH). It is registered-state derived only, with no combinational path from Out_ready_i.
- Out_valid_o = (count != 0). Result_o, Tag_o and Flags_o always present the head entry and hold stable while Out_valid_o=1 and Out_ready_i=0.
- Latency: a push in cycle N appears at the outputs in cycle N+1 when the buffer was empty. There is no same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Full: pushes are blocked, and a pop frees a slot visible the next cycle.
- Empty: a pop cannot occur.
- Pointers wrap modulo PARM_DEPTH.
- Packing at push time: word = {Sign_i, Exp_i, Mant_i}.
- NaN canonicalisation: Exp_i all ones with Mant_i != 0 stores 0x7FC00000, i.e. sign forced 0 and quiet bit set with all other mantissa bits 0.
- Infinity (all-ones exponent, zero mantissa) and zeros pass through with sign preserved.
- Stored flags = {Invalid_i, 1'b0, Overflow_i, Underflow_i, Inexact_i}. DZ is always 0 for FMA.
- Fflags accumulation happens on pop (retirement), not push: Fflags_o <= Fflags_o | head flags.
- Fflags_wr_i alone: Fflags_o <= Fflags_wdata_i.
- Fflags_wr_i in the same cycle as a pop: Fflags_o <= Fflags_wdata_i | head flags (the CSR write is ordered before the retiring op).
- Op_count_o increments by 1 on each pop and wraps from all-ones to 0. It is unaffected by Fflags_wr_i.

Test Plan:
- Reset then single op: push {0,0x80,0x000000}, NX=0 with Out_ready_i=1 -> Result_o=0x40000000 one cycle later. Next cycle Op_count_o=1, Fflags_o=0.
- NaN canonicalise: push sign=1, exp=0xFF, mant=0x000001, NV=1 -> Result_o=0x7FC00000, Flags_o=5'b10000. After pop, Fflags_o=5'b10000.
- Backpressure/full: Out_ready_i=0, push 3 consecutive ops (A, B, C) -> In_ready_o drops after 2 pushes and C is held upstream. Releasing Out_ready_i yields A, B, C in order, with Result_o stable while stalled.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, pointers wrap, no loss or duplication, and Op_count_o rises by exactly 10.
- Flag ordering: Fflags_o=5'b00001. In one cycle, Fflags_wr_i=1 with wdata=0 and pop an op with OF=1, NX=1 -> Fflags_o=5'b00101.
- Async reset asserted mid-stall with 2 entries buffered -> outputs clear immediately without waiting for a clock edge. After release, the first new push is the first to retire and Op_count_o restarts from 0.
